// File: rtl/inv_factorial_if.sv
// Request/result bundle for the inverse-factorial unit.
interface inv_factorial_if #(
    parameter int unsigned W = 28
) ();
    logic signed [W-1:0] d_in;
    logic                valid_in;
    logic                valid_out;
    logic                err;
    logic signed [W-1:0] n_out;
    logic                busy;

    modport master (
        output d_in, valid_in,
        input  valid_out, err, n_out, busy
    );

    modport slave (
        input  d_in, valid_in,
        output valid_out, err, n_out, busy
    );
endinterface

// File: rtl/inv_factorial.sv
// Inverse factorial: finds n with n! == d_in by iterating prod = k! until it
// matches, overshoots, or k reaches 11. Non-factorials return err with n_out all ones.
module inv_factorial #(
    parameter int unsigned W = 28
) (
    input  logic           clk,
    input  logic           rst,
    inv_factorial_if.slave bus
);
    localparam int unsigned PW    = 32;
    localparam int unsigned KW    = 4;
    localparam int unsigned EW    = 64;
    localparam int unsigned K_MAX = 11;
    localparam logic signed [EW-1:0] FACT_MAX = 64'sd39916800;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       prod_q, prod_d;
    logic [PW-1:0]       target_q, target_d;
    logic [KW-1:0]       k_q, k_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic signed [W-1:0] n_q, n_d;

    logic signed [EW-1:0] d_ext;
    logic                 in_range;

    // Sign-extend so the range test is exact for any W.
    assign d_ext    = EW'(bus.d_in);
    assign in_range = (d_ext >= 64'sd1) && (d_ext <= FACT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            prod_q   <= PW'(1);
            target_q <= '0;
            k_q      <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            n_q      <= '0;
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            target_q <= target_d;
            k_q      <= k_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            n_q      <= n_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_d  = state_q;
        prod_d   = prod_q;
        target_d = target_q;
        k_d      = k_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        n_d      = n_q;

        unique case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    if (!in_range) begin
                        err_d   = 1'b1;
                        n_d     = '1;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        target_d = PW'(d_ext);
                        k_d      = '0;
                        prod_d   = PW'(1);
                        err_d    = 1'b0;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (prod_q == target_q) begin
                    n_d     = W'(k_q);
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if ((prod_q > target_q) || (k_q == KW'(K_MAX))) begin
                    n_d     = '1;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    prod_d = PW'(prod_q * (PW'(k_q) + PW'(1)));
                    k_d    = k_q + KW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE);

    assign bus.valid_out = valid_q;
    assign bus.err       = err_q;
    assign bus.n_out     = n_q;
    assign bus.busy      = busy_q;
endmodule
